// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard-controller states and default widths.
package pipe_hazard_ctrl_pkg;

  localparam int DEF_REG_AW  = 5;
  localparam int DEF_CNT_W   = 16;
  localparam int STALL_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2
  } hzState_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts clocks with inc=1 and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze with
// stall save/restore, taken-branch flush, and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = DEF_REG_AW,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              mem_busy,
  input  logic              br_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [STALL_CNT_W-1:0] STALL_INIT  = STALL_CNT_W'(LOAD_STALL - 1);
  localparam bit                     MULTI_STALL = (LOAD_STALL > 1);

  hzState_t                 stateReg, stateNext, savedReg, savedNext, effState;
  logic [STALL_CNT_W-1:0]   cntReg, cntNext, savedCntReg, savedCntNext, effCnt;
  logic                     hz;

  assign hz = ex_memread && (ex_rt != '0) &&
              ((id_use_rs && (ex_rt == id_rs)) || (id_use_rt && (ex_rt == id_rt)));

  // Once memory is ready again, MEMWAIT acts as the interrupted state in that same cycle.
  assign effState = (stateReg == MEMWAIT) ? savedReg    : stateReg;
  assign effCnt   = (stateReg == MEMWAIT) ? savedCntReg : cntReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= RUN;
      cntReg      <= '0;
      savedReg    <= RUN;
      savedCntReg <= '0;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      savedReg    <= savedNext;
      savedCntReg <= savedCntNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    savedNext    = savedReg;
    savedCntNext = savedCntReg;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    pipe_freeze  = 1'b0;

    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      stateNext   = MEMWAIT;
      if (stateReg != MEMWAIT) begin
        savedNext    = stateReg;
        savedCntNext = cntReg;
      end
    end else if (br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      stateNext  = RUN;
      cntNext    = '0;
    end else begin
      case (effState)
        LDSTALL: begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          if (effCnt <= STALL_CNT_W'(1)) begin
            stateNext = RUN;
            cntNext   = '0;
          end else begin
            stateNext = LDSTALL;
            cntNext   = effCnt - STALL_CNT_W'(1);
          end
        end
        default: begin
          stateNext = RUN;
          cntNext   = '0;
          if (hz) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            if (MULTI_STALL) begin
              stateNext = LDSTALL;
              cntNext   = STALL_INIT;
            end
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk (clk),
    .rst (rst),
    .inc (~pc_we),
    .q   (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances, each exercised in turn
// while the others are held in reset.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst1, rst3, rst4;
  logic       exMemread, idUseRs, idUseRt, memBusy, brTaken;
  logic [4:0] exRt, idRs, idRt;

  logic        pw1, iw1, iff1, xf1, fz1;
  logic        pw3, iw3, iff3, xf3, fz3;
  logic        pw4, iw4, iff4, xf4, fz4;
  logic [15:0] sc1, sc3;
  logic [3:0]  sc4;
  logic [4:0]  o1, o3, o4;

  int tests  = 0;
  int failed = 0;

  // {pc_we, ifid_we, ifid_flush, idex_flush, pipe_freeze}
  localparam logic [4:0] RUNOK  = 5'b11000;
  localparam logic [4:0] BUBBLE = 5'b00010;
  localparam logic [4:0] FREEZE = 5'b00001;
  localparam logic [4:0] BRANCH = 5'b11110;
  localparam logic [4:0] RESETV = 5'b00110;

  always #5 clk = ~clk;

  assign o1 = {pw1, iw1, iff1, xf1, fz1};
  assign o3 = {pw3, iw3, iff3, xf3, fz3};
  assign o4 = {pw4, iw4, iff4, xf4, fz4};

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst1), .ex_memread(exMemread), .ex_rt(exRt), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .mem_busy(memBusy), .br_taken(brTaken),
    .pc_we(pw1), .ifid_we(iw1), .ifid_flush(iff1), .idex_flush(xf1), .pipe_freeze(fz1),
    .stall_cycles(sc1));

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst3), .ex_memread(exMemread), .ex_rt(exRt), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .mem_busy(memBusy), .br_taken(brTaken),
    .pc_we(pw3), .ifid_we(iw3), .ifid_flush(iff3), .idex_flush(xf3), .pipe_freeze(fz3),
    .stall_cycles(sc3));

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst4), .ex_memread(exMemread), .ex_rt(exRt), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .mem_busy(memBusy), .br_taken(brTaken),
    .pc_we(pw4), .ifid_we(iw4), .ifid_flush(iff4), .idex_flush(xf4), .pipe_freeze(fz4),
    .stall_cycles(sc4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] t=%0t %s observed %0h expected %0h", $time, tag, obs, exp);
  endtask

  task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] irt, input logic urs, input logic urt,
                       input logic busy, input logic br);
    exMemread = mr; exRt = rt; idRs = rs; idRt = irt;
    idUseRs = urs; idUseRt = urt; memBusy = busy; brTaken = br;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    idle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    chk("u1 reset outputs", 32'(o1), 32'(RESETV));
    chk("u1 reset count", 32'(sc1), 32'd0);
    chk("u3 reset outputs", 32'(o3), 32'(RESETV));

    // LOAD_STALL=1: single bubble on rs hazard
    nextCycle(); rst1 = 1'b0; idle();
    @(negedge clk); chk("u1 run idle", 32'(o1), 32'(RUNOK));
    nextCycle(); drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("u1 rs hazard bubble", 32'(o1), 32'(BUBBLE));
    nextCycle(); idle();
    @(negedge clk); chk("u1 after one bubble", 32'(o1), 32'(RUNOK));
    chk("u1 stall count 1", 32'(sc1), 32'd1);
    nextCycle(); drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("u1 r0 no hazard", 32'(o1), 32'(RUNOK));
    nextCycle(); drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("u1 rt invalid no hazard", 32'(o1), 32'(RUNOK));
    nextCycle(); drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("u1 branch beats hazard", 32'(o1), 32'(BRANCH));
    nextCycle(); idle();
    @(negedge clk); chk("u1 run after branch", 32'(o1), 32'(RUNOK));
    chk("u1 stall count still 1", 32'(sc1), 32'd1);
    rst1 = 1'b1;

    // LOAD_STALL=3: three bubbles on rt hazard
    nextCycle(); rst3 = 1'b0;
    drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("u3 bubble 1", 32'(o3), 32'(BUBBLE));
    nextCycle(); idle();
    @(negedge clk); chk("u3 bubble 2", 32'(o3), 32'(BUBBLE));
    nextCycle();
    @(negedge clk); chk("u3 bubble 3", 32'(o3), 32'(BUBBLE));
    nextCycle();
    @(negedge clk); chk("u3 run after 3", 32'(o3), 32'(RUNOK));
    chk("u3 stall count 3", 32'(sc3), 32'd3);

    // memory wait during the second bubble
    nextCycle(); drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("u3 mw bubble 1", 32'(o3), 32'(BUBBLE));
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); chk("u3 freeze 1", 32'(o3), 32'(FREEZE));
    nextCycle();
    @(negedge clk); chk("u3 freeze 2", 32'(o3), 32'(FREEZE));
    nextCycle(); idle();
    @(negedge clk); chk("u3 resume bubble 2", 32'(o3), 32'(BUBBLE));
    nextCycle();
    @(negedge clk); chk("u3 resume bubble 3", 32'(o3), 32'(BUBBLE));
    nextCycle();
    @(negedge clk); chk("u3 run after freeze", 32'(o3), 32'(RUNOK));
    chk("u3 stall count 8", 32'(sc3), 32'd8);

    // taken branch aborts a load stall
    nextCycle(); drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("u3 br bubble 1", 32'(o3), 32'(BUBBLE));
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("u3 branch in ldstall", 32'(o3), 32'(BRANCH));
    nextCycle(); idle();
    @(negedge clk); chk("u3 run after branch", 32'(o3), 32'(RUNOK));
    chk("u3 stall count 9", 32'(sc3), 32'd9);

    // new load in final stall cycle becomes a fresh hazard
    nextCycle(); drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("u3 fr bubble 1", 32'(o3), 32'(BUBBLE));
    nextCycle(); idle();
    @(negedge clk); chk("u3 fr bubble 2", 32'(o3), 32'(BUBBLE));
    nextCycle(); drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("u3 fr bubble 3", 32'(o3), 32'(BUBBLE));
    nextCycle();
    @(negedge clk); chk("u3 fresh bubble 1", 32'(o3), 32'(BUBBLE));
    nextCycle(); idle();
    @(negedge clk); chk("u3 fresh bubble 2", 32'(o3), 32'(BUBBLE));
    nextCycle();
    @(negedge clk); chk("u3 fresh bubble 3", 32'(o3), 32'(BUBBLE));
    nextCycle();
    @(negedge clk); chk("u3 run after fresh", 32'(o3), 32'(RUNOK));
    chk("u3 stall count 15", 32'(sc3), 32'd15);
    rst3 = 1'b1;

    // CNT_W=4 saturation under a permanent hazard
    nextCycle(); rst4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (i == 10) chk("u4 count mid", 32'(sc4), 32'd10);
      nextCycle();
    end
    @(negedge clk);
    chk("u4 stalled", 32'(o4), 32'(BUBBLE));
    chk("u4 saturated", 32'(sc4), 32'd15);
    #1 rst4 = 1'b1;
    #1;
    chk("u4 async reset count", 32'(sc4), 32'd0);
    chk("u4 reset outputs", 32'(o4), 32'(RESETV));
    nextCycle(); rst4 = 1'b0; idle();
    @(negedge clk);
    chk("u4 run after reset", 32'(o4), 32'(RUNOK));
    chk("u4 count after reset", 32'(sc4), 32'd0);
    nextCycle(); drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("u4 hazard from run", 32'(o4), 32'(BUBBLE));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-specifier width.
REQ-002 SHALL have parameter LOAD_STALL, default 1, legal range 1..15: bubbles inserted per load-use hazard.
REQ-003 SHALL have parameter CNT_W, default 16: stall performance-counter width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports ex_memread (input, 1), ex_rt (input, REG_AW): the load in EX and its destination.
REQ-007 SHALL have ports id_rs, id_rt (input, REG_AW each) and id_use_rs, id_use_rt (input, 1 each): ID source specifiers and their valid flags.
REQ-008 SHALL have port mem_busy, input, 1: data memory not ready; the whole pipeline freezes.
REQ-009 SHALL have port br_taken, input, 1: branch resolved taken in EX.
REQ-010 SHALL have ports pc_we, ifid_we (output, 1 each): PC and IF/ID write enables.
REQ-011 SHALL have ports ifid_flush, idex_flush (output, 1 each): clear to bubble.
REQ-012 SHALL have port pipe_freeze, output, 1: hold ID/EX, EX/MEM and MEM/WB.
REQ-013 SHALL have port stall_cycles, output, CNT_W: saturating count of cycles with pc_we=0.

Function
REQ-014 SHALL implement FSM states RUN, LDSTALL, MEMWAIT, plus a 4-bit down-counter cnt.
REQ-015 SHALL detect a hazard, hz, when ex_memread=1 AND ex_rt!=0 AND ((id_use_rs AND ex_rt==id_rs) OR (id_use_rt AND ex_rt==id_rt)); register 0 never hazards.
REQ-016 SHALL, in RUN with hz=1, combinationally drive pc_we=0, ifid_we=0, idex_flush=1 in the same cycle (bubble 1).
REQ-017 SHALL, in RUN with hz=1 and LOAD_STALL>1, go to LDSTALL with cnt=LOAD_STALL-1; with LOAD_STALL=1 it SHALL stay in RUN.
REQ-018 SHALL, in LDSTALL, drive pc_we=0, ifid_we=0, idex_flush=1 and decrement cnt each cycle, returning to RUN when cnt reaches 1; total bubbles SHALL be exactly LOAD_STALL.
REQ-019 SHALL, in RUN with no hz, mem_busy or br_taken, drive pc_we=1, ifid_we=1 and all flushes/freeze 0.
REQ-020 SHALL give mem_busy highest priority in any state: pipe_freeze=1, pc_we=0, ifid_we=0, flushes=0 (hold, not bubble); it SHALL enter MEMWAIT, save the interrupted state and cnt, and resume them unchanged the cycle after mem_busy drops.
REQ-021 SHALL give br_taken (with mem_busy=0) priority over hz and LDSTALL: ifid_flush=1, idex_flush=1, pc_we=1, ifid_we=1, next state RUN, cnt cleared.
REQ-022 SHALL increment stall_cycles on every clock with pc_we=0, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL treat hz from a new load arriving in the final LDSTALL cycle as a fresh hazard in the next RUN cycle.

Reset
REQ-024 SHALL, while rst=1 and asynchronously, force state=RUN, cnt=0, stall_cycles=0, saved state=RUN.
REQ-025 SHALL, while rst=1, drive pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, pipe_freeze=0.
REQ-026 SHALL, when rst asserts mid-LDSTALL or mid-MEMWAIT, abandon the stall; after release, behaviour SHALL be as from RUN.

Structure
REQ-027 SHALL put the state enum (RUN, LDSTALL, MEMWAIT) and the default REG_AW/CNT_W constants in the shared pipeline package.
REQ-028 SHALL implement stall_cycles as sub-module sat_counter (parameter W, ports clk, rst, inc, q).
REQ-029 SHALL be otherwise a single module with no latches; all outputs derive from state plus current inputs.

Verification
REQ-030 SHALL cover: LOAD_STALL=1, ex_memread=1, ex_rt=5, id_rs=5, id_use_rs=1 -> pc_we=0, idex_flush=1 for exactly 1 cycle; stall_cycles=1.
REQ-031 SHALL cover: LOAD_STALL=3, same hazard on rt -> exactly 3 consecutive bubble cycles, then pc_we=1; stall_cycles=3.
REQ-032 SHALL cover: ex_rt=0=id_rs with ex_memread=1, and ex_rt=7=id_rt with id_use_rt=0 -> no stall.
REQ-033 SHALL cover: LOAD_STALL=3, mem_busy=1 for 2 cycles during the second bubble -> pipe_freeze for 2 cycles, then the remaining bubbles resume; 5 total pc_we=0 cycles.
REQ-034 SHALL cover: br_taken=1 coincident with hz -> ifid_flush=idex_flush=1, pc_we=1, state RUN next cycle.
REQ-035 SHALL cover: CNT_W=4 with 20 stall cycles -> stall_cycles holds 15; rst pulse mid-LDSTALL -> stall_cycles=0, state RUN.
